wiggle_pattern_gen: RTL and testbench
=====================================

WIGGLE_PATTERN_GEN -- requirements
Module: wiggle_pattern_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, GPIO bank width (2..64).
REQ-002 SHALL have parameter DIV_W, default 24, prescaler divisor width.
REQ-003 SHALL have port osc  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port perstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cfg_valid  input  1  config offer.
REQ-006 SHALL have port cfg_ready  output  1  config accepted when cfg_valid & cfg_ready.
REQ-007 SHALL have port cfg_mode  input  2  0=binary count, 1=gray count, 2=walking one, 3=toggle.
REQ-008 SHALL have port cfg_div  input  DIV_W  step period minus one, in osc cycles.
REQ-009 SHALL have port enable  input  1  level; run request.
REQ-010 SHALL have port gpio_out  output  WIDTH  registered pattern.
REQ-011 SHALL have port tick  output  1  one-cycle pulse on each pattern step.
REQ-012 SHALL have port wrap  output  1  one-cycle pulse, coincident with tick, when the pattern returns to its initial value.

Function
REQ-013 SHALL implement FSM IDLE -> LOAD -> RUN -> IDLE.
REQ-014 IDLE: cfg_ready=1; config handshake latches mode/div; enable=1 -> LOAD next cycle.
REQ-015 cfg_valid and enable both high in one IDLE cycle SHALL capture the new config and use it in the run that follows.
REQ-016 LOAD (one cycle): cfg_ready=0; gpio_out loaded with mode initial value; prescaler cleared; -> RUN.
REQ-017 Initial values: binary/gray 0; walking one 1; toggle {WIDTH/2{2'b01}} (MSB-trimmed if WIDTH odd).
REQ-018 RUN: prescaler counts 0..div; tick asserts in the cycle count==div, count then returns to 0; div=0 -> tick every cycle.
REQ-019 First tick SHALL occur div+1 cycles after the LOAD cycle; gpio_out updates on the edge ending the tick cycle.
REQ-020 Binary: internal counter b+1 modulo 2^WIDTH; gpio_out=b.
REQ-021 Gray: same counter b; gpio_out=b^(b>>1), registered.
REQ-022 Walking one: rotate left by one; MSB wraps to bit 0.
REQ-023 Toggle: bitwise invert each step.
REQ-024 wrap SHALL assert on the tick whose update restores the initial value: binary/gray at b all-ones->0, walking at MSB->bit0, toggle every second tick.
REQ-025 cfg_ready=0 in LOAD and RUN; cfg_valid there SHALL be ignored, config unchanged.
REQ-026 enable=0 in RUN -> IDLE next cycle; a tick in that same cycle still completes; gpio_out then holds; prescaler cleared.
REQ-027 Re-entering RUN SHALL always restart from the mode initial value (via LOAD).

Reset
REQ-028 perstn=0 at a rising edge SHALL force: state IDLE, gpio_out=0, tick=0, wrap=0, cfg_ready=1 after release, mode=0, div=0, prescaler=0, counter=0.
REQ-029 Reset mid-RUN SHALL abort immediately at that edge; no partial step observable.
REQ-030 During perstn=0, cfg handshakes SHALL not be accepted (cfg_ready=0).

Structure
REQ-031 Package wiggle_pkg SHALL hold mode encodings (MODE_BIN, MODE_GRAY, MODE_WALK, MODE_TOGGLE) and the FSM state enum.
REQ-032 Prescaler SHALL be a sub-module wiggle_prescaler (ports osc, perstn, clr, div, tick).
REQ-033 No other sub-modules; pattern datapath and FSM in wiggle_pattern_gen.

Verification
REQ-034 WIDTH=8, cfg mode=0 div=0, enable=1 -> gpio_out 0x00,0x01,0x02.. one per cycle from cycle after LOAD; wrap with transition 0xFF->0x00 (256th tick).
REQ-035 WIDTH=8, mode=2 div=3 -> tick every 4 cycles, gpio_out 0x01,0x02..0x80,0x01; wrap on 8th tick.
REQ-036 WIDTH=8, mode=1 div=0 -> gpio_out 0x00,0x01,0x03,0x02,0x06; exactly one bit changes per tick.
REQ-037 WIDTH=8, mode=3 div=1 -> 0x55,0xAA,0x55 every 2 cycles; wrap on every 2nd tick; cfg_valid in RUN with mode=0 -> cfg_ready=0, pattern unaffected.
REQ-038 Running mode=0 div=0 at 0x10: drop enable -> gpio_out holds, state IDLE, cfg_ready=1; re-enable -> restarts at 0x00.
REQ-039 perstn=0 for 1 cycle mid-RUN at gpio_out=0x37 -> next edge gpio_out=0x00, tick=0, wrap=0, mode/div=0.

Source files
------------

// File: rtl/wiggle_pkg.sv
// Shared encodings for the wiggle pattern generator: pattern modes and FSM states.
package wiggle_pkg;

  typedef enum logic [1:0] {
    MODE_BIN    = 2'd0,
    MODE_GRAY   = 2'd1,
    MODE_WALK   = 2'd2,
    MODE_TOGGLE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/wiggle_prescaler.sv
// Step-rate prescaler: counts 0..div and flags the terminal count.
// While clr is high the count is held at zero so every run starts from a fresh period.
module wiggle_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             osc,
  input  logic             perstn,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] r_count;

  // Period counter: restarts at zero on clear or after reaching the divisor.
  always_ff @(posedge osc) begin
    if (!perstn) begin
      r_count <= '0;
    end else if (clr || (r_count == div)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + DIV_W'(1);
    end
  end

  assign tick = (r_count == div);

endmodule

// File: rtl/wiggle_pattern_gen.sv
// GPIO wiggle pattern generator: configurable binary/gray/walking-one/toggle
// patterns stepped at a programmable rate, with step and wrap pulses.
module wiggle_pattern_gen
  import wiggle_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIV_W = 24
) (
  input  logic             osc,
  input  logic             perstn,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             enable,
  output logic [WIDTH-1:0] gpio_out,
  output logic             tick,
  output logic             wrap
);

  state_e           r_state;
  state_e           w_next_state;
  mode_e            r_mode;
  logic [DIV_W-1:0] r_div;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_gpio;
  logic [WIDTH-1:0] w_cnt_inc;
  logic [WIDTH-1:0] w_next_gpio;
  logic [WIDTH-1:0] w_init;
  logic             w_pre_tick;
  logic             w_run;
  logic             w_clr;
  logic             w_accept;

  // Starting pattern of each mode; the toggle pattern is 0101.. from bit 0 upward.
  function automatic logic [WIDTH-1:0] init_value(input mode_e m);
    logic [WIDTH-1:0] v;
    v = '0;
    case (m)
      MODE_WALK:   v = {{(WIDTH-1){1'b0}}, 1'b1};
      MODE_TOGGLE: for (int i = 0; i < WIDTH; i++) v[i] = ~i[0];
      default:     v = '0;
    endcase
    return v;
  endfunction

  assign w_run     = (r_state == ST_RUN);
  // Clearing when enable drops lets the final tick finish while the count still returns to zero.
  assign w_clr     = !w_run || !enable;
  // Held low during reset so no handshake can complete while perstn is asserted.
  assign cfg_ready = (r_state == ST_IDLE) && perstn;
  assign w_accept  = cfg_valid && cfg_ready;
  assign tick      = w_run && w_pre_tick;
  assign w_cnt_inc = r_cnt + WIDTH'(1);
  assign w_init    = init_value(r_mode);
  // Every mode is a permutation cycle, so "next equals start" marks the wrap step.
  assign wrap      = tick && (w_next_gpio == w_init);
  assign gpio_out  = r_gpio;

  wiggle_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .osc    (osc),
    .perstn (perstn),
    .clr    (w_clr),
    .div    (r_div),
    .tick   (w_pre_tick)
  );

  // State register.
  always_ff @(posedge osc) begin
    if (!perstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: IDLE -> LOAD -> RUN, back to IDLE when enable drops.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (enable) w_next_state = ST_LOAD;
      ST_LOAD: w_next_state = ST_RUN;
      ST_RUN:  if (!enable) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Configuration capture, only in IDLE via the handshake.
  always_ff @(posedge osc) begin
    if (!perstn) begin
      r_mode <= MODE_BIN;
      r_div  <= '0;
    end else if (w_accept) begin
      r_mode <= mode_e'(cfg_mode);
      r_div  <= cfg_div;
    end
  end

  // Pattern value that the current step moves to.
  always_comb begin
    w_next_gpio = r_gpio;
    case (r_mode)
      MODE_BIN:    w_next_gpio = w_cnt_inc;
      MODE_GRAY:   w_next_gpio = w_cnt_inc ^ (w_cnt_inc >> 1);
      MODE_WALK:   w_next_gpio = {r_gpio[WIDTH-2:0], r_gpio[WIDTH-1]};
      MODE_TOGGLE: w_next_gpio = ~r_gpio;
      default:     w_next_gpio = r_gpio;
    endcase
  end

  // Pattern datapath: load the start value in LOAD, advance on each tick.
  always_ff @(posedge osc) begin
    if (!perstn) begin
      r_cnt  <= '0;
      r_gpio <= '0;
    end else if (r_state == ST_LOAD) begin
      r_cnt  <= '0;
      r_gpio <= w_init;
    end else if (tick) begin
      r_cnt  <= w_cnt_inc;
      r_gpio <= w_next_gpio;
    end
  end

endmodule

// File: tb/tb_wiggle_pattern_gen.sv
// Scoreboard bench for wiggle_pattern_gen (WIDTH=8): stimulus queues the expected
// pattern per tick, a negedge monitor pops and checks value, wrap and tick spacing.
module tb_wiggle_pattern_gen;

  logic        osc;
  logic        perstn;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_mode;
  logic [23:0] cfg_div;
  logic        enable;
  logic [7:0]  gpio_out;
  logic        tick;
  logic        wrap;

  typedef struct {
    int gpio;
    int wrp;
    int per;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_tick_cyc = 0;

  wiggle_pattern_gen #(
    .WIDTH (8),
    .DIV_W (24)
  ) dut (
    .osc       (osc),
    .perstn    (perstn),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mode  (cfg_mode),
    .cfg_div   (cfg_div),
    .enable    (enable),
    .gpio_out  (gpio_out),
    .tick      (tick),
    .wrap      (wrap)
  );

  initial osc = 1'b0;
  always #5 osc = ~osc;

  always @(posedge osc) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge osc);
    #1;
  endtask

  task automatic push(input int g, input int w, input int p);
    exp_t e;
    e.gpio = g;
    e.wrp  = w;
    e.per  = p;
    q.push_back(e);
  endtask

  task automatic cfg(input int m, input int d);
    chk("cfg_ready_idle", int'(cfg_ready), 1);
    cfg_valid = 1'b1;
    cfg_mode  = 2'(m);
    cfg_div   = 24'(d);
    step(1);
    cfg_valid = 1'b0;
  endtask

  function automatic int gray8(input int k);
    return (k ^ (k >> 1)) & 255;
  endfunction

  // Monitor: every tick must match the head of the expectation queue.
  always @(negedge osc) begin
    exp_t e;
    chk("wrap_without_tick", int'(wrap && !tick), 0);
    if (tick) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra_tick: got gpio 0x%0h with no expected step (cycle %0d)", gpio_out, cyc);
      end else begin
        e = q.pop_front();
        chk("sb_gpio", int'(gpio_out), e.gpio);
        chk("sb_wrap", int'(wrap), e.wrp);
        if (e.per != 0) chk("sb_period", cyc - last_tick_cyc, e.per);
      end
      last_tick_cyc = cyc;
    end
  end

  initial begin
    perstn    = 1'b0;
    cfg_valid = 1'b0;
    cfg_mode  = 2'd0;
    cfg_div   = 24'd0;
    enable    = 1'b0;
    step(2);
    chk("rst_gpio", int'(gpio_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_cfg_ready_low", int'(cfg_ready), 0);
    perstn = 1'b1;
    #1;
    chk("rel_cfg_ready", int'(cfg_ready), 1);
    step(1);

    // Binary, div 0: 257 steps covering the 0xFF -> 0x00 wrap.
    cfg(0, 0);
    for (int k = 0; k <= 256; k++) push(k & 255, (k == 255) ? 1 : 0, (k == 0) ? 0 : 1);
    enable = 1'b1;
    step(258);
    enable = 1'b0;
    step(1);
    chk("bin_hold_gpio", int'(gpio_out), 8'h01);
    chk("bin_idle_tick", int'(tick), 0);
    chk("bin_idle_ready", int'(cfg_ready), 1);

    // Walking one, div 3: first-tick latency then 9 steps, wrap on the 8th.
    cfg(2, 3);
    for (int k = 0; k <= 8; k++) push(1 << (k % 8), (k == 7) ? 1 : 0, (k == 0) ? 0 : 4);
    enable = 1'b1;
    step(1);
    chk("load_cfg_ready", int'(cfg_ready), 0);
    step(1);
    chk("walk_lat_c0", int'(tick), 0);
    step(1);
    chk("walk_lat_c1", int'(tick), 0);
    step(1);
    chk("walk_lat_c2", int'(tick), 0);
    step(1);
    chk("walk_lat_c3", int'(tick), 1);
    step(32);
    enable = 1'b0;
    step(1);

    // Gray, div 0: one bit changes per step.
    cfg(1, 0);
    push(8'h00, 0, 0);
    push(8'h01, 0, 1);
    push(8'h03, 0, 1);
    push(8'h02, 0, 1);
    push(8'h06, 0, 1);
    push(8'h07, 0, 1);
    enable = 1'b1;
    step(7);
    enable = 1'b0;
    step(1);

    // Toggle, div 1, with a config offer during RUN that must be ignored.
    cfg(3, 1);
    for (int k = 0; k < 5; k++) push((k % 2) ? 8'hAA : 8'h55, k % 2, (k == 0) ? 0 : 2);
    enable = 1'b1;
    step(4);
    cfg_valid = 1'b1;
    cfg_mode  = 2'd0;
    cfg_div   = 24'd0;
    #1;
    chk("run_cfg_ready", int'(cfg_ready), 0);
    step(3);
    cfg_valid = 1'b0;
    step(4);
    enable = 1'b0;
    step(1);
    // Config must still be toggle/div 1.
    push(8'h55, 0, 0);
    push(8'hAA, 1, 2);
    enable = 1'b1;
    step(5);
    enable = 1'b0;
    step(1);

    // Config and enable in the same IDLE cycle: the new walk config is used.
    cfg_valid = 1'b1;
    cfg_mode  = 2'd2;
    cfg_div   = 24'd0;
    enable    = 1'b1;
    push(8'h01, 0, 0);
    push(8'h02, 0, 1);
    push(8'h04, 0, 1);
    step(1);
    cfg_valid = 1'b0;
    step(3);
    enable = 1'b0;
    step(1);

    // Binary stopped at 0x10, holds in IDLE, restarts from 0x00.
    cfg(0, 0);
    for (int k = 0; k < 16; k++) push(k, 0, (k == 0) ? 0 : 1);
    enable = 1'b1;
    step(17);
    enable = 1'b0;
    step(1);
    chk("stop_gpio", int'(gpio_out), 8'h10);
    chk("stop_tick", int'(tick), 0);
    chk("stop_ready", int'(cfg_ready), 1);
    step(3);
    chk("stop_hold_gpio", int'(gpio_out), 8'h10);
    push(8'h00, 0, 0);
    push(8'h01, 0, 1);
    push(8'h02, 0, 1);
    enable = 1'b1;
    step(4);
    enable = 1'b0;
    step(1);

    // Gray, div 1, reset while showing 0x37; afterwards binary div 0 from defaults.
    cfg(1, 1);
    for (int k = 0; k <= 37; k++) push(gray8(k), 0, (k == 0) ? 0 : 2);
    enable = 1'b1;
    step(77);
    chk("pre_rst_gpio", int'(gpio_out), 8'h37);
    chk("pre_rst_tick", int'(tick), 1);
    perstn = 1'b0;
    enable = 1'b0;
    step(1);
    chk("midrst_gpio", int'(gpio_out), 0);
    chk("midrst_tick", int'(tick), 0);
    chk("midrst_wrap", int'(wrap), 0);
    chk("midrst_ready", int'(cfg_ready), 0);
    perstn = 1'b1;
    #1;
    chk("postrst_ready", int'(cfg_ready), 1);
    push(8'h00, 0, 0);
    push(8'h01, 0, 1);
    push(8'h02, 0, 1);
    enable = 1'b1;
    step(4);
    enable = 1'b0;
    step(3);

    chk("sb_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
